// File: rtl/sort_unit_elastic.sv
// ---------------------------------------------------------------------------
// sort_unit_elastic
//
// Purpose: a three-stage pipelined sorting network for four elements. It
// sorts each transaction ascending or descending, as the mode bit of that
// transaction asks. Every stage has valid/ready flow control with bubble
// collapsing, so a stage refills in the same cycle that it drains.
//
// Network:
//   S1 orders pairs (0,1) and (2,3).
//   S2 orders pairs (0,2) and (1,3).
//   S3 orders pair (1,2). Elements 0 and 3 pass through S3 unchanged.
//
// Parameters:
//   p_nbits   element width, 1..32
//   p_signed  0 = unsigned compare, 1 = two's-complement compare
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high; clears the valid bits (and the counter)
//   in_val/in_rdy    input handshake
//   in_desc          mode: 0 = ascending, 1 = descending
//   in0..in3         elements to sort
//   out_val/out_rdy  output handshake
//   out0..out3       sorted elements, forced to 0 while out_val=0
//   num_sorted       count of output transfers (only with SORT_UNIT_ELASTIC_COUNT_EN)
//
// Optional feature: define SORT_UNIT_ELASTIC_COUNT_EN to add the 32-bit
// num_sorted counter and its port. The counter wraps.
// ---------------------------------------------------------------------------
module sort_unit_elastic #(
  parameter int p_nbits  = 8,
  parameter int p_signed = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic               in_desc,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
`ifdef SORT_UNIT_ELASTIC_COUNT_EN
  output logic [31:0]        num_sorted,
`endif
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3
);

  // Strict greater-than in the configured number system.
  function automatic logic gt(input logic [p_nbits-1:0] a, input logic [p_nbits-1:0] b);
    if (p_signed != 0) gt = ($signed(a) > $signed(b));
    else               gt = (a > b);
  endfunction

  // True when the pair (lo index a, hi index b) must be exchanged. The
  // compare is strict, so equal elements never swap.
  function automatic logic swap_needed(input logic [p_nbits-1:0] a,
                                       input logic [p_nbits-1:0] b,
                                       input logic               desc);
    swap_needed = desc ? gt(b, a) : gt(a, b);
  endfunction

  // Stage state
  logic               s1_val_reg, s2_val_reg, s3_val_reg;
  logic               s1_desc_reg, s2_desc_reg, s3_desc_reg;
  logic [p_nbits-1:0] s1_e_reg [4];
  logic [p_nbits-1:0] s2_e_reg [4];
  logic [p_nbits-1:0] s3_e_reg [4];

  // Compare-swap results that feed each stage register
  logic [p_nbits-1:0] s1_e_next [4];
  logic [p_nbits-1:0] s2_e_next [4];
  logic [p_nbits-1:0] s3_e_next [4];

  // A stage loads when it is empty or when its current contents move on.
  // The chain runs from the output back to the input, so in_rdy depends
  // combinationally on out_rdy. out_val depends only on a register.
  logic load1, load2, load3;

  assign load3  = !s3_val_reg || out_rdy;
  assign load2  = !s2_val_reg || load3;
  assign load1  = !s1_val_reg || load2;
  assign in_rdy = load1;

  always_comb begin
    s1_e_next[0] = in0;
    s1_e_next[1] = in1;
    s1_e_next[2] = in2;
    s1_e_next[3] = in3;
    if (swap_needed(in0, in1, in_desc)) begin
      s1_e_next[0] = in1;
      s1_e_next[1] = in0;
    end
    if (swap_needed(in2, in3, in_desc)) begin
      s1_e_next[2] = in3;
      s1_e_next[3] = in2;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) s2_e_next[i] = s1_e_reg[i];
    if (swap_needed(s1_e_reg[0], s1_e_reg[2], s1_desc_reg)) begin
      s2_e_next[0] = s1_e_reg[2];
      s2_e_next[2] = s1_e_reg[0];
    end
    if (swap_needed(s1_e_reg[1], s1_e_reg[3], s1_desc_reg)) begin
      s2_e_next[1] = s1_e_reg[3];
      s2_e_next[3] = s1_e_reg[1];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) s3_e_next[i] = s2_e_reg[i];
    if (swap_needed(s2_e_reg[1], s2_e_reg[2], s2_desc_reg)) begin
      s3_e_next[1] = s2_e_reg[2];
      s3_e_next[2] = s2_e_reg[1];
    end
  end

  // Only the valid bits are reset. Element and mode registers may hold
  // stale values while their stage is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val_reg <= 1'b0;
      s2_val_reg <= 1'b0;
      s3_val_reg <= 1'b0;
    end else begin
      if (load1) s1_val_reg <= in_val;
      if (load2) s2_val_reg <= s1_val_reg;
      if (load3) s3_val_reg <= s2_val_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (load1) s1_desc_reg <= in_desc;
    if (load2) s2_desc_reg <= s1_desc_reg;
    if (load3) s3_desc_reg <= s2_desc_reg;
  end

  logic [p_nbits-1:0] out_arr [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (load1) s1_e_reg[gi] <= s1_e_next[gi];
        if (load2) s2_e_reg[gi] <= s2_e_next[gi];
        if (load3) s3_e_reg[gi] <= s3_e_next[gi];
      end
      assign out_arr[gi] = s3_val_reg ? s3_e_reg[gi] : '0;
    end
  endgenerate

  assign out_val = s3_val_reg;
  assign out0    = out_arr[0];
  assign out1    = out_arr[1];
  assign out2    = out_arr[2];
  assign out3    = out_arr[3];

`ifdef SORT_UNIT_ELASTIC_COUNT_EN
  logic [31:0] num_sorted_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       num_sorted_reg <= '0;
    else if (s3_val_reg && out_rdy)  num_sorted_reg <= num_sorted_reg + 32'd1;
  end

  assign num_sorted = num_sorted_reg;
`endif

endmodule

// File: tb/tb_sort_unit_elastic.sv
module tb_sort_unit_elastic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_val = 1'b0;
  logic       in_desc = 1'b0;
  logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic       out_rdy = 1'b1;

  logic       u_in_rdy, u_out_val, s_in_rdy, s_out_val;
  logic [7:0] uo0, uo1, uo2, uo3, so0, so1, so2, so3;
`ifdef SORT_UNIT_ELASTIC_COUNT_EN
  logic [31:0] u_count, s_count;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sort_unit_elastic #(.p_nbits(8), .p_signed(0)) dut_u (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(u_in_rdy), .in_desc(in_desc),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_val(u_out_val), .out_rdy(out_rdy),
`ifdef SORT_UNIT_ELASTIC_COUNT_EN
    .num_sorted(u_count),
`endif
    .out0(uo0), .out1(uo1), .out2(uo2), .out3(uo3));

  sort_unit_elastic #(.p_nbits(8), .p_signed(1)) dut_s (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(s_in_rdy), .in_desc(in_desc),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_val(s_out_val), .out_rdy(out_rdy),
`ifdef SORT_UNIT_ELASTIC_COUNT_EN
    .num_sorted(s_count),
`endif
    .out0(so0), .out1(so1), .out2(so2), .out3(so3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag,
                      input logic [7:0] o0, input logic [7:0] o1,
                      input logic [7:0] o2, input logic [7:0] o3,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".o0"}, {24'd0, o0}, {24'd0, e0});
    chk({tag, ".o1"}, {24'd0, o1}, {24'd0, e1});
    chk({tag, ".o2"}, {24'd0, o2}, {24'd0, e2});
    chk({tag, ".o3"}, {24'd0, o3}, {24'd0, e3});
    $display("txn %s: out={%0h,%0h,%0h,%0h}", tag, o0, o1, o2, o3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] e);
    in_val = 1'b1; in_desc = d; in0 = a; in1 = b; in2 = c; in3 = e;
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted
    #2;
    chk("rst.out_val", {31'd0, u_out_val}, 32'd0);
    chk("rst.in_rdy", {31'd0, u_in_rdy}, 32'd1);
    chk4("rst", uo0, uo1, uo2, uo3, 8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single ascending transaction: visible after the third edge
    drive(1'b0, 8'd3, 8'd1, 8'd4, 8'd2);
    chk("asc.in_rdy", {31'd0, u_in_rdy}, 32'd1);
    tick();
    in_val = 1'b0;
    chk("asc.early1", {31'd0, u_out_val}, 32'd0);
    tick();
    chk("asc.early2", {31'd0, u_out_val}, 32'd0);
    tick();
    chk("asc.out_val", {31'd0, u_out_val}, 32'd1);
    chk4("asc", uo0, uo1, uo2, uo3, 8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    chk("asc.after_val", {31'd0, u_out_val}, 32'd0);
    chk4("asc.zero", uo0, uo1, uo2, uo3, 8'd0, 8'd0, 8'd0, 8'd0);

    // Back-to-back transactions with mixed modes, including equal elements
    drive(1'b1, 8'd3, 8'd1, 8'd4, 8'd2);
    tick();
    drive(1'b0, 8'd5, 8'd5, 8'd0, 8'd9);
    tick();
    in_val = 1'b0;
    tick();
    chk("b2b.a.val", {31'd0, u_out_val}, 32'd1);
    chk4("b2b.desc", uo0, uo1, uo2, uo3, 8'd4, 8'd3, 8'd2, 8'd1);
    tick();
    chk("b2b.b.val", {31'd0, u_out_val}, 32'd1);
    chk4("b2b.asc", uo0, uo1, uo2, uo3, 8'd0, 8'd5, 8'd5, 8'd9);
    tick();
    chk("b2b.empty", {31'd0, u_out_val}, 32'd0);

    // Fill the pipeline under back-pressure, hold, then drain in order
    out_rdy = 1'b0;
    drive(1'b0, 8'd4, 8'd3, 8'd2, 8'd1);   tick();
    drive(1'b0, 8'd9, 8'd8, 8'd7, 8'd6);   tick();
    drive(1'b1, 8'd20, 8'd10, 8'd30, 8'd0); tick();
    drive(1'b0, 8'd99, 8'd98, 8'd97, 8'd96);
    for (int i = 0; i < 5; i++) begin
      chk("stall.in_rdy", {31'd0, u_in_rdy}, 32'd0);
      chk("stall.out_val", {31'd0, u_out_val}, 32'd1);
      chk4("stall.hold", uo0, uo1, uo2, uo3, 8'd1, 8'd2, 8'd3, 8'd4);
      tick();
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk("drain.in_rdy", {31'd0, u_in_rdy}, 32'd1);
    chk4("drain.t1", uo0, uo1, uo2, uo3, 8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    chk("drain.t2.val", {31'd0, u_out_val}, 32'd1);
    chk4("drain.t2", uo0, uo1, uo2, uo3, 8'd6, 8'd7, 8'd8, 8'd9);
    tick();
    chk("drain.t3.val", {31'd0, u_out_val}, 32'd1);
    chk4("drain.t3", uo0, uo1, uo2, uo3, 8'd30, 8'd20, 8'd10, 8'd0);
    tick();
    chk("drain.empty", {31'd0, u_out_val}, 32'd0);

    // Signed versus unsigned comparison on the same vector
    drive(1'b0, 8'h80, 8'h7F, 8'h00, 8'hFF);
    tick();
    in_val = 1'b0;
    tick(); tick();
    chk("sgn.val", {31'd0, s_out_val}, 32'd1);
    chk4("signed", so0, so1, so2, so3, 8'h80, 8'hFF, 8'h00, 8'h7F);
    chk4("unsigned", uo0, uo1, uo2, uo3, 8'h00, 8'h7F, 8'h80, 8'hFF);
    tick();

    // Asynchronous reset with two transactions in flight
    drive(1'b0, 8'd1, 8'd2, 8'd3, 8'd4); tick();
    drive(1'b0, 8'd5, 8'd6, 8'd7, 8'd8); tick();
    in_val = 1'b0;
    tick();
    chk("arst.pre_val", {31'd0, u_out_val}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_val", {31'd0, u_out_val}, 32'd0);
    chk("arst.in_rdy", {31'd0, u_in_rdy}, 32'd1);
    chk4("arst.zero", uo0, uo1, uo2, uo3, 8'd0, 8'd0, 8'd0, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst.no_stale", {31'd0, u_out_val}, 32'd0);
    end
    drive(1'b1, 8'd11, 8'd44, 8'd22, 8'd33);
    tick();
    in_val = 1'b0;
    tick();
    chk("arst.lat2", {31'd0, u_out_val}, 32'd0);
    tick();
    chk("arst.lat3", {31'd0, u_out_val}, 32'd1);
    chk4("arst.new", uo0, uo1, uo2, uo3, 8'd44, 8'd33, 8'd22, 8'd11);
    tick();

`ifdef SORT_UNIT_ELASTIC_COUNT_EN
    begin
      int sent, got, cyc;
      reset = 1'b1;
      #1;
      chk("cnt.reset", u_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      sent = 0; got = 0; cyc = 0;
      while (got < 10 && cyc < 300) begin
        out_rdy = 1'($urandom_range(0, 1));
        if (sent < 10) drive(1'b0, 8'(sent), 8'd7, 8'd3, 8'd1);
        else in_val = 1'b0;
        #1;
        if (in_val && u_in_rdy) sent++;
        if (u_out_val && out_rdy) got++;
        tick();
        cyc++;
      end
      in_val = 1'b0;
      out_rdy = 1'b0;
      chk("cnt.transfers", got, 32'd10);
      chk("cnt.ten", u_count, 32'd10);
      dut_u.num_sorted_reg = 32'hFFFF_FFFF;
      #1;
      drive(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
      tick();
      in_val = 1'b0;
      out_rdy = 1'b1;
      tick(); tick();
      chk("cnt.pre_wrap", u_count, 32'hFFFF_FFFF);
      tick();
      chk("cnt.wrap", u_count, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
